frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Downstream neighbour of the frame writer stage.
- On each `frame_ready` pulse it latches the frame base address and issues one INCR burst read of the whole frame to the AXI memory model.
- It buffers returned beats in a small FIFO and re-emits them as an AXI-Stream master: `tuser` marks start of frame, `tlast` marks end of line.
- It feeds the processing pipeline that consumes stored frames.

Parameters:
- ADDR_WIDTH, 32, width of memory addresses.
- DATA_WIDTH, 32, width of memory data and stream data (one pixel per beat).
- FIFO_DEPTH, 4, return-data FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- pixels_per_frame  in  32  beats per frame; sampled at frame start.
- frame_height  in  16  lines per frame; sampled at frame start.
- frame_width  in  16  pixels per line; sampled at frame start.
- frame_ready  in  1  one-cycle pulse: a stored frame is available.
- base_addr_in  in  ADDR_WIDTH  frame base address, valid with `frame_ready`.
- start_read  out  1  one-cycle burst-read request.
- read_addr  out  ADDR_WIDTH  burst start address.
- read_len  out  32  burst length in beats.
- read_size  out  3  beat size code.
- read_burst  out  2  burst type.
- read_data  in  DATA_WIDTH  returned beat.
- read_valid  in  1  `read_data` valid.
- read_ready  out  1  block accepts a beat.
- m_axis_tdata  out  DATA_WIDTH  stream pixel.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame.
- busy  out  1  a frame is in flight.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted downstream.

Behaviour:
- Reset (`rst` high at a `clk` edge): all outputs 0; FSM goes to IDLE; FIFO is flushed; counters, pending slot and latched sizes are cleared. Reset mid-frame aborts the frame with no `frame_done`.
- States:
  - IDLE: on `frame_ready` (or a valid pending slot), latch the base address, `pixels_per_frame`, `frame_width` and `frame_height`, then go to REQ.
  - REQ: for exactly one cycle, drive `start_read`=1 with `read_addr`=latched base, `read_len`=latched `pixels_per_frame`, `read_size`=2, `read_burst`=1 (INCR), then go to STREAM. Outside REQ these outputs are 0.
  - STREAM: runs until the last pixel handshakes downstream, then go to DONE.
  - DONE: pulse `frame_done` for one cycle; go to IDLE. If the pending slot is valid, IDLE starts the next frame on the following cycle.
- `busy` is 1 in REQ, STREAM and DONE.
- Return path:
  - `read_ready` = (state==STREAM) and FIFO not full and beats_received < latched `pixels_per_frame`.
  - A beat is written to the FIFO when `read_valid` and `read_ready` are both high. `read_valid` while `read_ready` is low is not consumed.
- Stream path:
  - `m_axis_tvalid` = FIFO not empty; `m_axis_tdata` = FIFO head.
  - The head pops on `tvalid` and `tready`. Simultaneous push and pop on a full FIFO is allowed.
  - Minimum latency from an accepted beat into an empty FIFO to `tvalid` is 1 cycle.
  - `tdata`, `tlast` and `tuser` stay stable while `tvalid` is high and `tready` is low.
- Counters (16-bit `col`/`row`, 32-bit `beats_received`/`beats_sent`; all cleared on frame start):
  - `tuser` = 1 only when `beats_sent`==0.
  - `tlast` = 1 when `col`==latched `frame_width`-1.
  - On each handshake `col` increments; at `frame_width`-1 it wraps to 0 and `row` increments.
  - The frame ends on the handshake where `beats_sent`==latched `pixels_per_frame`-1.
  - `pixels_per_frame` ≠ `frame_width`×`frame_height` is not checked; `beats_sent` governs termination.
- Pending slot:
  - `frame_ready` while `busy` stores `base_addr_in` in a one-entry pending slot.
  - A second `frame_ready` while the slot is full overwrites it; the older frame is dropped.
- Zero sizes: `frame_ready` with `pixels_per_frame`==0 or `frame_width`==0 is ignored and the FSM stays in IDLE.

Optional Feature:
- Macro: FRAME_READER_DROP_CNT_EN.
- Defined:
  - Adds output `dropped_frames` (16-bit, reset 0). It increments, saturating at 0xFFFF, on every overwrite of a full pending slot.
  - Adds output `underrun` (1-bit, sticky until reset). It sets when STREAM has `tready` high with the FIFO empty for 16 consecutive cycles.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Frame 4×2, `pixels_per_frame`=8, base 0x10, memory returns data 0..7, `tready` always 1 -> one `start_read` with addr 0x10, len 8, size 2, burst 1; stream 0..7; `tuser` on beat 0; `tlast` on beats 3 and 7; `frame_done` 1 cycle after beat 7; `busy` low after that.
- Same frame with `tready` toggling 1,0,0,1 -> `read_ready` drops when FIFO holds 4; no beat lost or duplicated; data held stable while stalled.
- `frame_ready` at base 0x0 then `frame_ready` at base 0x20 mid-frame -> second burst starts at 0x20 within 2 cycles after the first `frame_done`.
- Three `frame_ready` pulses during one frame -> only the last pending base is read; with the macro defined, `dropped_frames`=1.
- `rst` asserted on pixel 3 of an 8-pixel frame -> all outputs 0 next cycle, no `frame_done`; a new `frame_ready` restarts cleanly with `tuser` on the first beat.
- `frame_ready` with `pixels_per_frame`=0 -> no `start_read`; `busy` stays 0.

Source files
------------

// File: rtl/frame_reader.sv
// frame_reader: burst-reads a stored frame and replays it as an AXI-Stream.
// Optional FRAME_READER_DROP_CNT_EN adds dropped_frames and underrun outputs.
module frame_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pixels_per_frame,
  input  logic [15:0]           frame_height,
  input  logic [15:0]           frame_width,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_valid,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done
`ifdef FRAME_READER_DROP_CNT_EN
  ,
  output logic [15:0]           dropped_frames,
  output logic                  underrun
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_base, r_pend_addr;
  logic                  r_pend_valid;
  logic [31:0]           r_ppf, r_rcvd, r_sent;
  logic [15:0]           r_width, r_height;
  logic [15:0]           r_col, r_row;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr, r_rptr;

  logic w_sizes_ok, w_fr_ok, w_idle;
  logic w_start_new, w_start_pend, w_start;
  logic w_empty, w_full, w_push, w_pop, w_last;

  assign w_sizes_ok   = (pixels_per_frame != 32'd0)
                     && (frame_width != 16'd0);
  assign w_fr_ok      = frame_ready && w_sizes_ok;
  assign w_idle       = (r_state == S_IDLE);
  assign w_start_new  = w_idle && w_fr_ok;
  assign w_start_pend = w_idle && !frame_ready
                     && r_pend_valid && w_sizes_ok;
  assign w_start      = w_start_new || w_start_pend;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW])
                && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = read_valid && read_ready;
  assign w_pop   = m_axis_tvalid && m_axis_tready;
  assign w_last  = w_pop && (r_sent == r_ppf - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_REQ;
      S_REQ:    w_next = S_STREAM;
      S_STREAM: if (w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // A fresh frame_ready in IDLE wins over a stale pending base.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base       <= '0;
      r_ppf        <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_pend_addr  <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_start) begin
      r_base       <= w_start_new ? base_addr_in : r_pend_addr;
      r_ppf        <= pixels_per_frame;
      r_width      <= frame_width;
      r_height     <= frame_height;
      r_pend_valid <= 1'b0;
    end else if (busy && w_fr_ok) begin
      r_pend_addr  <= base_addr_in;
      r_pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_col  <= '0;
      r_row  <= '0;
      r_rcvd <= '0;
      r_sent <= '0;
    end else begin
      if (w_push) r_rcvd <= r_rcvd + 32'd1;
      if (w_pop) begin
        r_sent <= r_sent + 32'd1;
        if (r_col == r_width - 16'd1) begin
          r_col <= '0;
          r_row <= (r_row == r_height - 16'd1) ? 16'd0
                                               : r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  assign busy       = !w_idle;
  assign frame_done = (r_state == S_DONE);
  assign start_read = (r_state == S_REQ);
  assign read_addr  = start_read ? r_base : '0;
  assign read_len   = start_read ? r_ppf : 32'd0;
  assign read_size  = start_read ? 3'd2 : 3'd0;
  assign read_burst = start_read ? 2'd1 : 2'd0;
  assign read_ready = (r_state == S_STREAM) && !w_full
                   && (r_rcvd < r_ppf);

  // Sideband is gated by tvalid so an idle stream shows all zeros.
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rptr[AW-1:0]] : '0;
  assign m_axis_tuser  = m_axis_tvalid && (r_sent == 32'd0);
  assign m_axis_tlast  = m_axis_tvalid
                      && (r_col == r_width - 16'd1);

`ifdef FRAME_READER_DROP_CNT_EN
  logic [15:0] r_dropped;
  logic [3:0]  r_starve;
  logic        r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropped  <= '0;
      r_starve   <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (busy && w_fr_ok && r_pend_valid
          && r_dropped != 16'hFFFF)
        r_dropped <= r_dropped + 16'd1;
      if (r_state == S_STREAM && m_axis_tready && w_empty) begin
        if (r_starve == 4'd15) r_underrun <= 1'b1;
        else                   r_starve   <= r_starve + 4'd1;
      end else begin
        r_starve <= '0;
      end
    end
  end

  assign dropped_frames = r_dropped;
  assign underrun       = r_underrun;
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: frame vector table plus
// pending-slot, reset and zero-size sequences.
module tb_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pixels_per_frame;
  logic [15:0] frame_height;
  logic [15:0] frame_width;
  logic        frame_ready;
  logic [31:0] base_addr_in;
  logic        start_read;
  logic [31:0] read_addr;
  logic [31:0] read_len;
  logic [2:0]  read_size;
  logic [1:0]  read_burst;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;
  logic        frame_done;
`ifdef FRAME_READER_DROP_CNT_EN
  logic [15:0] dropped_frames;
  logic        underrun;
`endif

  frame_reader dut (
    .clk(clk),
    .rst(rst),
    .pixels_per_frame(pixels_per_frame),
    .frame_height(frame_height),
    .frame_width(frame_width),
    .frame_ready(frame_ready),
    .base_addr_in(base_addr_in),
    .start_read(start_read),
    .read_addr(read_addr),
    .read_len(read_len),
    .read_size(read_size),
    .read_burst(read_burst),
    .read_data(read_data),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .busy(busy),
    .frame_done(frame_done)
`ifdef FRAME_READER_DROP_CNT_EN
    ,
    .dropped_frames(dropped_frames),
    .underrun(underrun)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] ppf;
    logic [15:0] w;
  } fexp_t;

  fexp_t       exp_q[$];
  fexp_t       e;
  logic [3:0]  pat = 4'b1111;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          sr_cnt = 0;
  int          tl_cnt = 0;
  int          beat_cnt = 0;
  int          occ = 0;
  int          maxocc = 0;
  int          last_fd_cyc = 0;
  int          sr_gap = 0;
  logic [31:0] mem_addr, mem_len, mem_idx;
  logic        mem_act, mem_hs;
  logic [31:0] cur_base, cur_ppf, sent;
  logic [15:0] cur_w, col;
  logic        cur_act, exp_fd;
  logic        stall_prev;
  logic [31:0] prev_data;
  logic        prev_last, prev_user;

  // Memory model, stream sink and scoreboard; inputs change at negedge.
  initial begin
    read_valid = 1'b0;
    read_data = '0;
    m_axis_tready = 1'b0;
    mem_act = 1'b0;
    mem_hs = 1'b0;
    mem_addr = '0;
    mem_len = '0;
    mem_idx = '0;
    cur_act = 1'b0;
    cur_base = '0;
    cur_ppf = '0;
    cur_w = '0;
    sent = '0;
    col = '0;
    exp_fd = 1'b0;
    stall_prev = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    prev_user = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_hs) mem_idx = mem_idx + 32'd1;
      if (rst) begin
        mem_act = 1'b0;
        mem_hs = 1'b0;
        read_valid = 1'b0;
        m_axis_tready = 1'b0;
        occ = 0;
        cur_act = 1'b0;
        exp_fd = 1'b0;
        stall_prev = 1'b0;
      end else begin
        check("frame_done", frame_done, exp_fd);
        if (frame_done) begin
          fd_cnt++;
          last_fd_cyc = cyc;
        end
        exp_fd = 1'b0;
        if (start_read) begin
          sr_cnt++;
          sr_gap = cyc - last_fd_cyc;
          maxocc = 0;
          mem_act = 1'b1;
          mem_addr = read_addr;
          mem_len = read_len;
          mem_idx = '0;
          check("sr_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sr_addr", read_addr, e.base);
            check("sr_len", read_len, e.ppf);
            check("sr_size", read_size, 3'd2);
            check("sr_burst", read_burst, 2'd1);
            cur_base = e.base;
            cur_ppf = e.ppf;
            cur_w = e.w;
            sent = '0;
            col = '0;
            cur_act = 1'b1;
          end
        end
        check("tvalid_occ", m_axis_tvalid, occ != 0);
        if (occ == 4) check("rready_full", read_ready, 0);
        if (stall_prev) begin
          check("hold_valid", m_axis_tvalid, 1);
          check("hold_data", m_axis_tdata, prev_data);
          check("hold_last", m_axis_tlast, prev_last);
          check("hold_user", m_axis_tuser, prev_user);
        end
        m_axis_tready = pat[cyc % 4];
        read_valid = mem_act && (mem_idx < mem_len);
        read_data = (mem_addr << 8) + mem_idx;
        mem_hs = read_valid && read_ready;
        if (m_axis_tvalid && m_axis_tready) begin
          beat_cnt++;
          if (m_axis_tlast) tl_cnt++;
          check("beat_expected", cur_act, 1);
          check("tdata", m_axis_tdata, (cur_base << 8) + sent);
          check("tuser", m_axis_tuser, sent == 32'd0);
          check("tlast", m_axis_tlast, col == cur_w - 16'd1);
          sent = sent + 32'd1;
          col = (col == cur_w - 16'd1) ? 16'd0 : col + 16'd1;
          if (cur_act && sent == cur_ppf) begin
            exp_fd = 1'b1;
            cur_act = 1'b0;
          end
          occ--;
        end
        if (mem_hs) occ++;
        if (occ > maxocc) maxocc = occ;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        prev_user = m_axis_tuser;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fr(input logic [31:0] a);
    frame_ready = 1'b1;
    base_addr_in = a;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic wait_fd(input int target, input string nm);
    int k = 0;
    while (fd_cnt < target && k < 400) begin
      tick();
      k++;
    end
    check(nm, fd_cnt >= target, 1);
  endtask

  task automatic chk_idle();
    check("z_ctl", {start_read, read_ready, m_axis_tvalid,
                    m_axis_tlast, m_axis_tuser, busy,
                    frame_done}, 0);
    check("z_addr", read_addr, 0);
    check("z_len", read_len, 0);
    check("z_szb", {read_size, read_burst}, 0);
    check("z_data", m_axis_tdata, 0);
`ifdef FRAME_READER_DROP_CNT_EN
    check("z_drop", {dropped_frames, underrun}, 0);
`endif
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] ppf;
    logic [15:0] w;
    logic [15:0] h;
    logic [3:0]  pat;
    logic [31:0] tl;
    logic        full;
  } vec_t;

  vec_t vt[5];

  initial begin
    int fd0, sr0, tl0, b0, bz;

    vt[0] = '{32'h10,  32'd8,  16'd4, 16'd2, 4'b1111, 32'd2, 1'b0};
    vt[1] = '{32'h10,  32'd16, 16'd4, 16'd4, 4'b1001, 32'd4, 1'b1};
    vt[2] = '{32'h40,  32'd6,  16'd3, 16'd2, 4'b1111, 32'd2, 1'b0};
    vt[3] = '{32'h80,  32'd5,  16'd2, 16'd3, 4'b1111, 32'd2, 1'b0};
    vt[4] = '{32'hC0,  32'd3,  16'd1, 16'd3, 4'b1111, 32'd3, 1'b0};

    rst = 1'b1;
    frame_ready = 1'b0;
    base_addr_in = '0;
    pixels_per_frame = 32'd8;
    frame_width = 16'd4;
    frame_height = 16'd2;
    repeat (3) tick();
    chk_idle();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      pixels_per_frame = vt[i].ppf;
      frame_width = vt[i].w;
      frame_height = vt[i].h;
      pat = vt[i].pat;
      sr0 = sr_cnt;
      tl0 = tl_cnt;
      b0 = beat_cnt;
      fd0 = fd_cnt;
      exp_q.push_back('{vt[i].base, vt[i].ppf, vt[i].w});
      pulse_fr(vt[i].base);
      wait_fd(fd0 + 1, "v_done");
      check("v_sr", sr_cnt - sr0, 1);
      check("v_beats", beat_cnt - b0, vt[i].ppf);
      check("v_tlast", tl_cnt - tl0, vt[i].tl);
      check("v_full", maxocc == 4, vt[i].full);
      check("v_busy", busy, 0);
    end

    pixels_per_frame = 32'd8;
    frame_width = 16'd4;
    frame_height = 16'd2;
    pat = 4'b1111;

    fd0 = fd_cnt;
    sr0 = sr_cnt;
    exp_q.push_back('{32'h0, 32'd8, 16'd4});
    exp_q.push_back('{32'h20, 32'd8, 16'd4});
    pulse_fr(32'h0);
    tick();
    tick();
    pulse_fr(32'h20);
    wait_fd(fd0 + 2, "a_done");
    check("a_sr", sr_cnt - sr0, 2);
    check("a_gap", sr_gap, 2);
    check("a_q", exp_q.size(), 0);
    check("a_busy", busy, 0);

    fd0 = fd_cnt;
    sr0 = sr_cnt;
    exp_q.push_back('{32'h100, 32'd8, 16'd4});
    exp_q.push_back('{32'h300, 32'd8, 16'd4});
    pulse_fr(32'h100);
    tick();
    pulse_fr(32'h200);
    tick();
    pulse_fr(32'h300);
    wait_fd(fd0 + 2, "b_done");
    check("b_sr", sr_cnt - sr0, 2);
    check("b_gap", sr_gap, 2);
    check("b_q", exp_q.size(), 0);
`ifdef FRAME_READER_DROP_CNT_EN
    check("b_dropped", dropped_frames, 16'd1);
`endif

    fd0 = fd_cnt;
    exp_q.push_back('{32'h40, 32'd8, 16'd4});
    pulse_fr(32'h40);
    for (int k = 0; k < 100; k++) begin
      if (cur_act && sent == 32'd3) break;
      tick();
    end
    check("r_reach", sent, 3);
    rst = 1'b1;
    tick();
    chk_idle();
    rst = 1'b0;
    repeat (10) tick();
    check("r_nofd", fd_cnt, fd0);
    check("r_idle", busy, 0);
    sr0 = sr_cnt;
    b0 = beat_cnt;
    exp_q.push_back('{32'h60, 32'd8, 16'd4});
    pulse_fr(32'h60);
    wait_fd(fd0 + 1, "r_done");
    check("r_sr", sr_cnt - sr0, 1);
    check("r_beats", beat_cnt - b0, 8);

    sr0 = sr_cnt;
    bz = 0;
    pixels_per_frame = 32'd0;
    pulse_fr(32'h500);
    for (int k = 0; k < 8; k++) begin
      if (busy) bz++;
      tick();
    end
    pixels_per_frame = 32'd8;
    frame_width = 16'd0;
    pulse_fr(32'h600);
    for (int k = 0; k < 8; k++) begin
      if (busy) bz++;
      tick();
    end
    check("z_sr", sr_cnt - sr0, 0);
    check("z_busy", bz, 0);
`ifdef FRAME_READER_DROP_CNT_EN
    check("underrun", underrun, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
